// File: rtl/frame_buffer_scanout_pkg.sv
// Shared constants and FSM encoding for the frame-buffer scanout block.
package frame_buffer_scanout_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned BytesPerWord = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

endpackage

// File: rtl/frame_buffer_scanout_if.sv
// RAM load port and pixel stream of the scanout engine, bundled for the top-level port list.
interface frame_buffer_scanout_if;

  logic [frame_buffer_scanout_pkg::DataWidth-1:0] ram_address;
  logic                                           ram_load;
  logic                                           ram_grant;
  logic [frame_buffer_scanout_pkg::DataWidth-1:0] ram_rdata;
  logic [7:0]                                     pixel_data;
  logic                                           pixel_valid;
  logic                                           pixel_ready;
  logic                                           pixel_last;

  modport master (
    output ram_address, ram_load, pixel_data, pixel_valid, pixel_last,
    input  ram_grant, ram_rdata, pixel_ready
  );

  modport slave (
    input  ram_address, ram_load, pixel_data, pixel_valid, pixel_last,
    output ram_grant, ram_rdata, pixel_ready
  );

endinterface

// File: rtl/scanout_word_fifo.sv
// Synchronous word FIFO with a combinational head read; Depth must be a power of two.
module scanout_word_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_din,
  output logic [Width-1:0] o_dout,
  output logic [CntW-1:0]  o_count,
  output logic             o_empty
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_full    = (r_count == CntW'(Depth));
  assign o_empty   = (r_count == '0);
  // Push+pop together is always allowed, even at the full/empty boundaries.
  assign w_do_push = i_push && (!w_full || i_pop);
  assign w_do_pop  = i_pop && (!o_empty || i_push);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/frame_buffer_scanout.sv
// Frame-buffer scanout: fetches the frame word by word over the RAM load port and streams it
// out as little-endian bytes on a valid/ready pixel interface.
module frame_buffer_scanout
  import frame_buffer_scanout_pkg::*;
#(
  parameter int unsigned FB_START   = 0,
  parameter int unsigned FB_SIZE    = 64,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  frame_buffer_scanout_if.master bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [DataWidth-1:0] LastAddr = DataWidth'(FB_START + FB_SIZE - BytesPerWord);
  localparam logic [DataWidth-1:0] LastWord = DataWidth'(FB_SIZE / BytesPerWord - 1);

  state_e               r_state;
  state_e               w_state_d;
  logic [DataWidth-1:0] r_fetch_addr;
  logic [DataWidth-1:0] w_fetch_addr_d;
  logic [DataWidth-1:0] r_out_word;
  logic [DataWidth-1:0] w_out_word_d;
  logic [1:0]           r_byte_sel;
  logic [1:0]           w_byte_sel_d;
  logic                 r_inflight;
  logic                 r_done;
  logic                 w_done_d;

  logic [DataWidth-1:0] w_fifo_dout;
  logic [CntW-1:0]      w_fifo_count;
  logic                 w_fifo_empty;
  logic                 w_ram_load;
  logic                 w_accept;
  logic                 w_pix_valid;
  logic                 w_pix_fire;
  logic                 w_word_end;
  logic                 w_pop;
  logic                 w_last;
  logic [7:0]           w_pix_byte;

  // A word in flight already owns a FIFO slot, so the FIFO cannot overflow.
  assign w_ram_load  = (r_state == StFetch) &&
                       ((32'(w_fifo_count) + 32'(r_inflight)) < FIFO_DEPTH);
  assign w_accept    = w_ram_load && bus.ram_grant;
  assign w_pix_valid = !w_fifo_empty;
  assign w_pix_fire  = w_pix_valid && bus.pixel_ready;
  assign w_word_end  = (r_byte_sel == 2'(BytesPerWord - 1));
  assign w_pop       = w_pix_fire && w_word_end;
  assign w_last      = w_pix_valid && w_word_end && (r_out_word == LastWord);

  scanout_word_fifo #(
    .Width (DataWidth),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   (bus.ram_rdata),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_state_d      = r_state;
    w_fetch_addr_d = r_fetch_addr;
    w_out_word_d   = r_out_word;
    w_byte_sel_d   = r_byte_sel;
    w_done_d       = 1'b0;

    if (w_pix_fire) begin
      w_byte_sel_d = r_byte_sel + 2'd1;
      if (w_word_end) begin
        w_out_word_d = r_out_word + 32'd1;
      end
    end

    unique case (r_state)
      StIdle: begin
        // The cycle showing done still counts as busy for start purposes.
        if (i_start && !r_done) begin
          w_state_d      = StFetch;
          w_fetch_addr_d = DataWidth'(FB_START);
          w_out_word_d   = '0;
          w_byte_sel_d   = '0;
        end
      end
      StFetch: begin
        if (w_accept) begin
          w_fetch_addr_d = r_fetch_addr + DataWidth'(BytesPerWord);
          if (r_fetch_addr == LastAddr) begin
            w_state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (w_last && bus.pixel_ready) begin
          w_state_d = StIdle;
          w_done_d  = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_fetch_addr <= '0;
      r_out_word   <= '0;
      r_byte_sel   <= '0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_fetch_addr <= w_fetch_addr_d;
      r_out_word   <= w_out_word_d;
      r_byte_sel   <= w_byte_sel_d;
      r_inflight   <= w_accept;
      r_done       <= w_done_d;
    end
  end

  always_comb begin
    w_pix_byte = 8'h00;
    if (w_pix_valid) begin
      unique case (r_byte_sel)
        2'd0: w_pix_byte = w_fifo_dout[7:0];
        2'd1: w_pix_byte = w_fifo_dout[15:8];
        2'd2: w_pix_byte = w_fifo_dout[23:16];
        2'd3: w_pix_byte = w_fifo_dout[31:24];
        default: w_pix_byte = 8'h00;
      endcase
    end
  end

  assign bus.ram_address = r_fetch_addr;
  assign bus.ram_load    = w_ram_load;
  assign bus.pixel_data  = w_pix_byte;
  assign bus.pixel_valid = w_pix_valid;
  assign bus.pixel_last  = w_last;
  assign o_busy          = (r_state != StIdle);
  assign o_done          = r_done;

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Scoreboard bench: a byte-level frame model feeds expectation queues, monitors pop and compare.
module tb_frame_buffer_scanout;
  import frame_buffer_scanout_pkg::*;

  localparam int FbStart = 32'h100;
  localparam int FbSize  = 64;
  localparam int FifoDep = 4;
  localparam int SmStart = 32'h200;
  localparam int SmSize  = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b, busy_a, busy_b, done_a, done_b;
  always #5 clk = ~clk;

  frame_buffer_scanout_if bus_a ();
  frame_buffer_scanout_if bus_b ();

  frame_buffer_scanout #(
    .FB_START   (FbStart),
    .FB_SIZE    (FbSize),
    .FIFO_DEPTH (FifoDep)
  ) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start_a),
    .o_busy  (busy_a),
    .o_done  (done_a),
    .bus     (bus_a)
  );

  frame_buffer_scanout #(
    .FB_START   (SmStart),
    .FB_SIZE    (SmSize),
    .FIFO_DEPTH (2)
  ) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (start_b),
    .o_busy  (busy_b),
    .o_done  (done_b),
    .bus     (bus_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int grant_mode_a = 0, ready_mode_a = 0, grant_mode_b = 0, ready_mode_b = 0;
  int acc_a = 0, acc_b = 0, hs_a = 0, hs_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int first_cyc_a = 0, last_cyc_a = 0;
  logic exp_done_a = 1'b0, exp_done_b = 1'b0;
  logic [31:0] mem_a [FbSize/4];
  logic [31:0] mem_b;
  pix_t        exp_q_a[$], exp_q_b[$];
  logic [31:0] exp_addr_a[$], exp_addr_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // 0: high, 1: repeating 1,0,0,1, 2: low, 3: random
  function automatic logic pick(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return ((c % 4) == 0) || ((c % 4) == 3);
      2:       return 1'b0;
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus_a.ram_grant = 1'b0; bus_a.pixel_ready = 1'b0;
    bus_b.ram_grant = 1'b0; bus_b.pixel_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus_a.ram_grant   = pick(grant_mode_a, cyc);
      bus_a.pixel_ready = pick(ready_mode_a, cyc);
      bus_b.ram_grant   = pick(grant_mode_b, cyc);
      bus_b.pixel_ready = pick(ready_mode_b, cyc);
    end
  end

  // RAM model for both initiators: check the address, return data the next cycle.
  initial begin
    logic acc_va, acc_vb;
    logic [31:0] addr_va, addr_vb, ex;
    int idx;
    bus_a.ram_rdata = '0;
    bus_b.ram_rdata = '0;
    forever begin
      @(negedge clk); #4;
      acc_va  = rst_n && bus_a.ram_load && bus_a.ram_grant;
      acc_vb  = rst_n && bus_b.ram_load && bus_b.ram_grant;
      addr_va = bus_a.ram_address;
      addr_vb = bus_b.ram_address;
      if (acc_va) begin
        acc_a++;
        ex = (exp_addr_a.size() != 0) ? exp_addr_a.pop_front() : 32'hFFFF_FFFF;
        check("ram_addr_a", addr_va, ex);
      end
      if (acc_vb) begin
        acc_b++;
        ex = (exp_addr_b.size() != 0) ? exp_addr_b.pop_front() : 32'hFFFF_FFFF;
        check("ram_addr_b", addr_vb, ex);
      end
      @(posedge clk); #1;
      idx = int'((addr_va - 32'(FbStart)) >> 2);
      bus_a.ram_rdata = (acc_va && idx >= 0 && idx < FbSize / 4) ? mem_a[idx] : $urandom;
      bus_b.ram_rdata = (acc_vb && addr_vb == 32'(SmStart)) ? mem_b : $urandom;
    end
  end

  initial begin
    pix_t e;
    logic stall_q = 1'b0;
    logic [7:0] held = 8'h00;
    forever begin
      @(negedge clk); #4;
      if (!rst_n) begin
        stall_q = 1'b0;
        continue;
      end
      if (exp_done_a || done_a) check("done_a", 32'(done_a), 32'(exp_done_a));
      if (done_a) done_cnt_a++;
      exp_done_a = 1'b0;
      if (stall_q && bus_a.pixel_valid) check("hold_a", 32'(bus_a.pixel_data), 32'(held));
      stall_q = bus_a.pixel_valid && !bus_a.pixel_ready;
      held    = bus_a.pixel_data;
      if (bus_a.pixel_valid && bus_a.pixel_ready) begin
        if (hs_a == 0) first_cyc_a = cyc;
        hs_a++;
        last_cyc_a = cyc;
        if (exp_q_a.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pix_extra_a: got byte 0x%0h, expected no byte", bus_a.pixel_data);
        end else begin
          e = exp_q_a.pop_front();
          check("pix_data_a", 32'(bus_a.pixel_data), 32'(e.data));
          check("pix_last_a", 32'(bus_a.pixel_last), 32'(e.last));
          exp_done_a = e.last;
        end
      end
    end
  end

  initial begin
    pix_t e;
    forever begin
      @(negedge clk); #4;
      if (!rst_n) continue;
      if (exp_done_b || done_b) check("done_b", 32'(done_b), 32'(exp_done_b));
      if (done_b) done_cnt_b++;
      exp_done_b = 1'b0;
      if (bus_b.pixel_valid && bus_b.pixel_ready) begin
        hs_b++;
        if (exp_q_b.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pix_extra_b: got byte 0x%0h, expected no byte", bus_b.pixel_data);
        end else begin
          e = exp_q_b.pop_front();
          check("pix_data_b", 32'(bus_b.pixel_data), 32'(e.data));
          check("pix_last_b", 32'(bus_b.pixel_last), 32'(e.last));
          exp_done_b = e.last;
        end
      end
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < FbSize / 4; i++) mem_a[i] = $urandom;
    mem_a[0] = 32'h4433_2211;
    mem_a[1] = 32'h8877_6655;
    mem_b    = $urandom;
  endtask

  // Model: byte k of the frame is byte (k mod 4) of word k/4; the last byte carries pixelLast.
  task automatic start_frame(input bit which);
    int nb;
    logic [31:0] base, w;
    pix_t p;
    nb   = which ? SmSize : FbSize;
    base = which ? 32'(SmStart) : 32'(FbStart);
    for (int k = 0; k < nb; k++) begin
      w      = which ? mem_b : mem_a[k / 4];
      p.data = w[8 * (k % 4) +: 8];
      p.last = (k == nb - 1);
      if (which) exp_q_b.push_back(p);
      else exp_q_a.push_back(p);
    end
    for (int i = 0; i < nb / 4; i++) begin
      if (which) exp_addr_b.push_back(base + 32'(4 * i));
      else exp_addr_a.push_back(base + 32'(4 * i));
    end
    @(negedge clk);
    if (which) begin hs_b = 0; acc_b = 0; start_b = 1'b1; end
    else begin hs_a = 0; acc_a = 0; start_a = 1'b1; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check(which ? "busy_start_b" : "busy_start_a", 32'(which ? busy_b : busy_a), 32'd1);
    check(which ? "load_start_b" : "load_start_a",
          32'(which ? bus_b.ram_load : bus_a.ram_load), 32'd1);
  endtask

  // Returns at the negedge where done is visible.
  task automatic wait_done(input bit which);
    int n;
    n = 0;
    while (!(which ? done_b : done_a) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout_done_%0d: got no done in %0d cycles, expected a done pulse", which, n);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_busy"}, 32'(busy_a), 32'd0);
    check({tag, "_done"}, 32'(done_a), 32'd0);
    check({tag, "_load"}, 32'(bus_a.ram_load), 32'd0);
    check({tag, "_addr"}, bus_a.ram_address, 32'd0);
    check({tag, "_valid"}, 32'(bus_a.pixel_valid), 32'd0);
    check({tag, "_data"}, 32'(bus_a.pixel_data), 32'd0);
    check({tag, "_last"}, 32'(bus_a.pixel_last), 32'd0);
  endtask

  initial begin
    int n, d0;
    rst_n = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_idle_a("rst");
    check("rst_valid_b", 32'(bus_b.pixel_valid), 32'd0);
    check("rst_busy_b", 32'(busy_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic scan: latency, consecutive bytes, done one cycle after the last byte.
    fill_mem();
    start_frame(1'b0);
    @(negedge clk);
    check("latency_nvalid", 32'(bus_a.pixel_valid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(bus_a.pixel_valid), 32'd1);
    check("latency_byte0", 32'(bus_a.pixel_data), 32'h11);
    wait_done(1'b0);
    check("rate_a", 32'(last_cyc_a - first_cyc_a), 32'(FbSize - 1));
    check("done_delay_a", 32'(cyc - last_cyc_a), 32'd1);
    start_a = 1'b1;  // coincides with done, must be ignored
    @(negedge clk);
    start_a = 1'b0;
    check("start_on_done", 32'(busy_a), 32'd0);
    repeat (2) @(negedge clk);
    check("done_cnt_basic", 32'(done_cnt_a), 32'd1);

    // Grant gaps: same memory, so the same stream; address queue rejects duplicates.
    grant_mode_a = 1;
    start_frame(1'b0);
    wait_done(1'b0);
    repeat (2) @(negedge clk);
    check("acc_gaps", 32'(acc_a), 32'(FbSize / 4));
    check("done_cnt_gaps", 32'(done_cnt_a), 32'd2);

    // Backpressure: loads stop once the FIFO holds FIFO_DEPTH words.
    grant_mode_a = 0;
    ready_mode_a = 2;
    fill_mem();
    start_frame(1'b0);
    repeat (20) begin
      @(negedge clk);
      if (bus_a.pixel_valid) check("bp_data", 32'(bus_a.pixel_data), 32'h11);
    end
    check("bp_acc", 32'(acc_a), 32'(FifoDep));
    ready_mode_a = 3;
    wait_done(1'b0);
    repeat (2) @(negedge clk);

    // Start pulse mid-frame is ignored.
    grant_mode_a = 3;
    d0 = done_cnt_a;
    fill_mem();
    start_frame(1'b0);
    repeat (15) @(negedge clk);
    check("busy_mid", 32'(busy_a), 32'd1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0);
    repeat (6) @(negedge clk);
    check("one_done", 32'(done_cnt_a - d0), 32'd1);
    check("bytes_left_a", 32'(exp_q_a.size()), 32'd0);

    // Reset after three bytes, then a full new frame.
    grant_mode_a = 0;
    ready_mode_a = 0;
    start_frame(1'b0);
    n = 0;
    while (hs_a < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("three_bytes", 32'(hs_a), 32'd3);
    #2 rst_n = 1'b0;
    #1 check_idle_a("midrst");
    exp_q_a.delete();
    exp_addr_a.delete();
    exp_done_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_frame(1'b0);
    wait_done(1'b0);
    repeat (2) @(negedge clk);

    // A couple of fully random frames.
    for (int f = 0; f < 2; f++) begin
      grant_mode_a = 3;
      ready_mode_a = 3;
      fill_mem();
      start_frame(1'b0);
      wait_done(1'b0);
      repeat (2) @(negedge clk);
    end

    // Single-word frame on the second instance.
    grant_mode_b = 3;
    ready_mode_b = 0;
    start_frame(1'b1);
    wait_done(1'b1);
    repeat (3) @(negedge clk);
    check("acc_single", 32'(acc_b), 32'd1);
    check("hs_single", 32'(hs_b), 32'd4);
    ready_mode_b = 3;
    mem_b = $urandom;
    start_frame(1'b1);
    wait_done(1'b1);
    repeat (3) @(negedge clk);
    check("acc_single2", 32'(acc_b), 32'd1);
    check("done_cnt_b", 32'(done_cnt_b), 32'd2);

    check("end_q_a", 32'(exp_q_a.size()), 32'd0);
    check("end_q_b", 32'(exp_q_b.size()), 32'd0);
    check("end_addr_a", 32'(exp_addr_a.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_buffer_scanout.md
# frame_buffer_scanout

Read-side counterpart to the core's frame-buffer stores. On a start pulse it walks the frame-buffer region of main memory word by word through the RAM load port, buffers the words, and streams them out as bytes over a valid/ready pixel interface. It sits beside the memory controller as a second RAM initiator; an external arbiter grants it the RAM port only when the core is not using it.

## Interface
- DATA_WIDTH, 32: RAM word width; fixed at 32 (4 bytes per word).
- FB_START, 0: frame-buffer byte base address; multiple of 4.
- FB_SIZE, 64: frame-buffer length in bytes; multiple of 4, ≥ 4.
- FIFO_DEPTH, 4: word FIFO entries; power of two, ≥ 2.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame scan; ignored while busy.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse after the final byte handshake.
- ramAddress  out  DATA_WIDTH  byte address of the requested word, always word-aligned.
- ramLoad  out  1  load request; held with ramAddress stable until granted.
- ramGrant  in  1  arbiter grant; a load is accepted on a rising edge where ramLoad && ramGrant.
- ramDataRead  in  DATA_WIDTH  read data, valid in the cycle after acceptance.
- pixelData  out  8  current byte.
- pixelValid  out  1  pixelData is valid.
- pixelReady  in  1  consumer accepts the byte on a rising edge where pixelValid && pixelReady.
- pixelLast  out  1  marks the final byte of the frame; qualified by pixelValid.

## Operation
- States:
  - IDLE: start → FETCH. Word counter and byte counter are cleared and fetchAddr = FB_START.
  - FETCH: issues loads. After the load for the last word (FB_START+FB_SIZE−4) is accepted → DRAIN.
  - DRAIN: no new loads. Transitions to IDLE after the last byte handshake.
- Credit rule: ramLoad = (state==FETCH) && (fifoCount + inflight < FIFO_DEPTH). inflight is 1 in the cycle after acceptance.
  - Back-to-back accepted loads are allowed; this gives one word per cycle under continuous grant.
- On acceptance:
  - fetchAddr += 4.
  - Next cycle: ramDataRead is pushed into the FIFO.
  - The FIFO can never overflow.
- Output unpacking:
  - The head word is emitted byte 0 first (bits 7:0), then bytes 1, 2 and 3, matching the little-endian store layout.
  - The head word is popped on the handshake of byte 3.
- pixelValid = FIFO non-empty. pixelData is held stable while pixelValid && !pixelReady.
- pixelLast = 1 on byte 3 of word FB_SIZE/4−1.
- Address arithmetic is DATA_WIDTH-bit unsigned. Wrap past 2^32 is not supported; the parameters must not cause it.
- Grant withdrawn while ramLoad is high: the request is held unchanged. No request is dropped and none is duplicated.

## Timing
- Reset (asynchronous, active-low) values:
  - state=IDLE; all outputs 0, including ramAddress=0, pixelData=0 and done=0.
  - FIFO is empty, inflight=0, and all counters are 0.
- Reset asserted mid-scan:
  - Aborts immediately and discards the FIFO and any in-flight word.
  - After release, the block waits in IDLE for a new start.
- Latency with continuous grant and pixelReady:
  - start edge: busy=1 and ramLoad=1 in the next cycle.
  - First pixelValid occurs 2 cycles after the first acceptance.
- Sustained rate is 1 byte/cycle, so fetch outpaces the output. A full frame takes about FB_SIZE + 3 cycles.
- done pulses in the cycle after the pixelLast handshake; busy falls in the same cycle.
- start is ignored in the same cycle as done. A new start is accepted from the next cycle.
- FB_SIZE=4 (single word): FETCH→DRAIN occurs on the first acceptance.

## Structure
- Shared package/`include: DATA_WIDTH, bytes-per-word (4), and the state encoding (IDLE/FETCH/DRAIN).
- Sub-module scanout_word_fifo:
  - Synchronous FIFO parameterised by width and depth.
  - Ports: push, pop, din, dout, count, empty.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push+pop while full or empty is legal; count is unchanged.
- The top level holds the FSM, the credit counter, the address and word counters, and the byte-select mux.

## Test plan
- Basic scan:
  - Setup: FB_START=0x100, FB_SIZE=8, memory words 0x44332211 and 0x88776655, grant and ready tied high.
  - Required response: bytes 11,22,…,88 on consecutive cycles; pixelLast only on 88; done one cycle later.
- Grant gaps:
  - Stimulus: ramGrant toggles 1,0,0,1 repeatedly.
  - Required response: ramAddress sequence is exactly 0x100, 0x104 with no duplicates; the output byte stream is identical to the basic scan.
- Backpressure:
  - Stimulus: pixelReady low for 20 cycles with FB_SIZE=64 and FIFO_DEPTH=4.
  - Required response: accepted loads stop at 4 words; pixelData stays 0x11 throughout; the stream resumes intact.
- Start while busy:
  - Stimulus: a second start pulse mid-frame.
  - Required response: ignored; exactly FB_SIZE bytes and one done pulse.
- Reset mid-scan:
  - Stimulus: reset low after 3 bytes are output.
  - Required response: outputs zero asynchronously. A new start then yields a full frame beginning at 0x11.
- Single-word frame:
  - Stimulus: FB_SIZE=4.
  - Required response: 4 bytes are output; pixelLast on byte 3; ramLoad is accepted once.
